// File: rtl/mod_counter_pkg.sv
// Shared defaults and the per-edge operation type for mod_counter.
// The macros are the shared bus-width default and the direction constants.
`ifndef MOD_COUNTER_DEFS
`define MOD_COUNTER_DEFS
`define DATA_WIDTH 8
`define CNT_UP     1'b1
`define CNT_DOWN   1'b0
`endif

package mod_counter_pkg;

    localparam int DEF_WIDTH = `DATA_WIDTH;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/mod_counter_tristate_buffer.sv
// Generic tristate driver for the shared data bus; also used by register blocks.
module tristate_buffer #(
    parameter int WIDTH = `DATA_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output wire  [WIDTH-1:0] out
);

    assign out = en ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/mod_counter.sv
// Bus-attached up/down counter with programmable modulus, wrap/saturate mode
// and a combinational terminal count for cascading.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int     WIDTH = `DATA_WIDTH,
    parameter longint MOD   = longint'(1) << WIDTH,
    parameter bit     WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] data,
    input  logic             CS,
    input  logic             EN,
    input  logic             OE,
    input  logic             CNT_EN,
    input  logic             UP,
    output logic             TC
);

    // Held as a WIDTH-bit constant so MOD = 2**WIDTH gives all-ones, not an overflow.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_q;
    logic             w_at_last;
    logic             w_at_zero;
    logic             w_oe;
    cnt_op_e          w_op;

    // Out-of-range loaded values count as "at last", so an up-count wraps or holds.
    assign w_at_last = (r_q >= LAST);
    assign w_at_zero = (r_q == '0);
    assign w_oe      = CS & OE & ~EN;
    assign TC        = CNT_EN & ((UP == `CNT_UP) ? w_at_last : w_at_zero);

    always_comb begin
        w_op = OP_HOLD;
        if (CS && EN)
            w_op = OP_LOAD;
        else if (CNT_EN)
            w_op = (UP == `CNT_UP) ? OP_UP : OP_DOWN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (w_op)
                OP_LOAD: r_q <= data;
                OP_UP:   r_q <= w_at_last ? (WRAP ? '0 : r_q) : r_q + 1'b1;
                OP_DOWN: r_q <= w_at_zero ? (WRAP ? LAST : '0) : r_q - 1'b1;
                default: r_q <= r_q;
            endcase
        end
    end

    tristate_buffer #(.WIDTH(WIDTH)) u_drv (
        .in  (r_q),
        .en  (w_oe),
        .out (data)
    );

endmodule

// File: tb/tb_mod_counter.sv
// Drives three counter variants (MOD=10 wrap, MOD=10 saturate, MOD=256 wrap)
// in lockstep and compares bus reads and TC against a plain arithmetic model.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 0, en = 0, oe = 0, cnt = 0, up = 0;
    logic [7:0] dval = 8'h00;
    logic       drv;
    wire  [7:0] d10w, d10s, d256;
    logic       tc10w, tc10s, tc256;

    int n_vec = 0;
    int n_err = 0;
    int m10w = 0, m10s = 0, m256 = 0;

    always #5 clk = ~clk;

    // Bench drives the bus whenever the counters are not reading onto it.
    assign drv  = !(cs && oe && !en);
    assign d10w = drv ? dval : 8'bz;
    assign d10s = drv ? dval : 8'bz;
    assign d256 = drv ? dval : 8'bz;

    mod_counter #(.WIDTH(8), .MOD(10), .WRAP(1'b1)) u10w (
        .clk(clk), .reset(reset), .data(d10w), .CS(cs), .EN(en), .OE(oe),
        .CNT_EN(cnt), .UP(up), .TC(tc10w));
    mod_counter #(.WIDTH(8), .MOD(10), .WRAP(1'b0)) u10s (
        .clk(clk), .reset(reset), .data(d10s), .CS(cs), .EN(en), .OE(oe),
        .CNT_EN(cnt), .UP(up), .TC(tc10s));
    mod_counter #(.WIDTH(8), .MOD(256), .WRAP(1'b1)) u256 (
        .clk(clk), .reset(reset), .data(d256), .CS(cs), .EN(en), .OE(oe),
        .CNT_EN(cnt), .UP(up), .TC(tc256));

    function automatic int nxt(int q, int md, bit wrap, bit c, bit e, bit ce, bit u, int d);
        if (c && e)      return d;
        if (ce && u)     return (q >= md - 1) ? (wrap ? 0 : q) : q + 1;
        if (ce && !u)    return (q == 0) ? (wrap ? md - 1 : 0) : q - 1;
        return q;
    endfunction

    function automatic int tcm(int q, int md, bit ce, bit u);
        return (ce && (u ? (q >= md - 1) : (q == 0))) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clocked step: check combinational outputs before the edge, then advance model.
    task automatic apply(input string tag, input bit c, input bit e, input bit o,
                         input bit ce, input bit u, input int d);
        cs = c; en = e; oe = o; cnt = ce; up = u; dval = 8'(d);
        #1;
        chk({tag, "_tc10w"}, int'(tc10w), tcm(m10w, 10, ce, u));
        chk({tag, "_tc10s"}, int'(tc10s), tcm(m10s, 10, ce, u));
        chk({tag, "_tc256"}, int'(tc256), tcm(m256, 256, ce, u));
        if (c && o && !e) begin
            chk({tag, "_rd10w"}, int'(d10w), m10w);
            chk({tag, "_rd10s"}, int'(d10s), m10s);
            chk({tag, "_rd256"}, int'(d256), m256);
        end
        @(posedge clk);
        m10w = nxt(m10w, 10, 1'b1, c, e, ce, u, d & 255);
        m10s = nxt(m10s, 10, 1'b0, c, e, ce, u, d & 255);
        m256 = nxt(m256, 256, 1'b1, c, e, ce, u, d & 255);
        @(negedge clk);
    endtask

    // Unclocked bus read of all three counters against fixed expectations.
    task automatic rd(input string tag, input int e10w, input int e10s, input int e256);
        cs = 1; en = 0; oe = 1; cnt = 0;
        #1;
        chk({tag, "_10w"}, int'(d10w), e10w);
        chk({tag, "_10s"}, int'(d10s), e10s);
        chk({tag, "_256"}, int'(d256), e256);
    endtask

    initial begin
        #12;
        @(negedge clk);
        reset = 1'b0;

        rd("t1_rst", 0, 0, 0);
        up = 1; cnt = 1; #1;
        chk("t1_tc10w", int'(tc10w), 0);
        chk("t1_tc256", int'(tc256), 0);

        apply("t2_ld", 1, 1, 0, 0, 1, 8'h07);
        apply("t2_a", 1, 0, 1, 1, 1, 0);
        rd("t2_q8", 8, 8, 8);
        apply("t2_b", 1, 0, 1, 1, 1, 0);
        rd("t2_q9", 9, 9, 9);
        cnt = 1; up = 1; #1;
        chk("t2_tc9", int'(tc10w), 1);
        apply("t2_c", 1, 0, 1, 1, 1, 0);
        rd("t2_wrap", 0, 9, 8'h0A);

        apply("t3_ld", 1, 1, 0, 0, 0, 0);
        apply("t3_dn", 1, 0, 1, 1, 0, 0);
        rd("t3_q", 9, 0, 8'hFF);
        cnt = 1; up = 0; #1;
        chk("t3_tchold", int'(tc10s), 1);

        apply("t4_ldcnt", 1, 1, 0, 1, 1, 8'h05);
        rd("t4_q", 5, 5, 5);

        cs = 1; en = 1; oe = 1; cnt = 0; dval = 8'hAB; #1;
        chk("t5_bus", int'(d256), 8'hAB);
        apply("t5_ld", 1, 1, 1, 0, 1, 8'hAB);
        rd("t5_q", 8'hAB, 8'hAB, 8'hAB);
        apply("t5_oor", 1, 0, 1, 1, 1, 0);
        rd("t5_oorq", 0, 8'hAB, 8'hAC);
        apply("t5_ldff", 1, 1, 0, 0, 1, 8'hFF);
        cnt = 1; up = 1; #1;
        chk("t5_tcff", int'(tc256), 1);
        apply("t5_up", 1, 0, 1, 1, 1, 0);
        rd("t5_wrap", 0, 8'hFF, 0);

        apply("t6_ld", 1, 1, 0, 0, 1, 8'h03);
        apply("t6_up", 1, 0, 1, 1, 1, 0);
        cs = 1; en = 0; oe = 1; cnt = 1; up = 1;
        #1 reset = 1'b1;
        #1;
        chk("t6_rst10w", int'(d10w), 0);
        chk("t6_rst256", int'(d256), 0);
        m10w = 0; m10s = 0; m256 = 0;
        reset = 1'b0;
        @(posedge clk);
        m10w = 1; m10s = 1; m256 = 1;
        @(negedge clk);
        rd("t6_resume", 1, 1, 1);

        for (int i = 0; i < 400; i++) begin
            int d;
            case ($urandom_range(0, 5))
                0: d = 0;
                1: d = 9;
                2: d = 10;
                3: d = 255;
                default: d = int'($urandom_range(0, 255));
            endcase
            apply("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), d);
        end
        rd("final", m10w, m10s, m256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
